// File: rtl/uart_bridge_pkg.sv
// Shared command/response codes and frame FSM states for the UART bus bridge.
// S_CSUM exists only when UART_BRIDGE_CSUM_EN is defined.
package uart_bridge_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
`ifdef UART_BRIDGE_CSUM_EN
        S_CSUM,
`endif
        S_REQ,
        S_ACC,
        S_RESP
    } state_t;

endpackage

// File: rtl/uart_bridge_rx_byte.sv
// UART byte receiver: 2-flop synchroniser, half-bit start qualification, mid-bit sampling.
// Latency: byte_vld/byte_ferr pulse one cycle at the stop-bit sample point.
// Backpressure: none; consumer must take the byte in the pulse cycle.
module uart_bridge_rx_byte #(
    parameter int BAUDCNT = 48
) (
    input  logic       clk_48m,
    input  logic       rstn,
    input  logic       rxd,
    output logic [7:0] byte_dat,
    output logic       byte_vld,
    output logic       byte_ferr,
    output logic       active
);

    localparam int             CW      = $clog2(BAUDCNT);
    localparam logic [CW-1:0]  HALF_M1 = CW'(BAUDCNT / 2 - 1);
    localparam logic [CW-1:0]  FULL_M1 = CW'(BAUDCNT - 1);

    logic [1:0]    sync;
    logic          rx_s;
    logic          armed;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    sh;

    assign rx_s = sync[1];

    // After a framing error the line must return high before a new start is
    // accepted, otherwise a held-low stop bit would look like a fresh start.
    always_ff @(posedge clk_48m) begin
        if (!rstn) begin
            sync      <= 2'b11;
            armed     <= 1'b0;
            active    <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            sh        <= '0;
            byte_dat  <= '0;
            byte_vld  <= 1'b0;
            byte_ferr <= 1'b0;
        end else begin
            sync      <= {sync[0], rxd};
            byte_vld  <= 1'b0;
            byte_ferr <= 1'b0;
            if (!active) begin
                if (rx_s) begin
                    armed <= 1'b1;
                    cnt   <= '0;
                end else if (armed) begin
                    if (cnt == HALF_M1) begin
                        active  <= 1'b1;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end else if (cnt == FULL_M1) begin
                cnt <= '0;
                if (bit_idx == 4'd8) begin
                    active <= 1'b0;
                    if (rx_s) begin
                        byte_vld <= 1'b1;
                        byte_dat <= sh;
                    end else begin
                        byte_ferr <= 1'b1;
                        armed     <= 1'b0;
                    end
                end else begin
                    sh      <= {rx_s, sh[7:1]};
                    bit_idx <= bit_idx + 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART debug bridge: framed R/W commands on rxd become single 32-bit bus accesses, reply on txd (UART_BRIDGE_CSUM_EN adds a checksum byte).
// Latency: bus access the cycle after bus_gnt; reply start bit begins the cycle after the access.
// Backpressure: waits on bus_gnt without limit; bytes arriving during REQ/ACC/RESP are dropped.
module uart_bus_bridge
    import uart_bridge_pkg::*;
#(
    parameter int BAUDCNT    = 48,
    parameter int TMO_CYCLES = 480000
) (
    input  logic        clk_48m,
    input  logic        rstn,
    input  logic        rxd,
    output logic        txd,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        m_sel,
    output logic [31:0] m_addr,
    output logic [31:0] m_data_o,
    input  logic [31:0] m_data_i,
    output logic        m_rd,
    output logic        m_wr,
    output logic        busy
);

    localparam int            CW      = $clog2(BAUDCNT);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUDCNT - 1);
    localparam int            TW      = $clog2(TMO_CYCLES);
    localparam logic [TW-1:0] TMO_M1  = TW'(TMO_CYCLES - 1);
`ifdef UART_BRIDGE_CSUM_EN
    localparam state_t AFTER_FIELDS = S_CSUM;
`else
    localparam state_t AFTER_FIELDS = S_REQ;
`endif

    state_t        state, state_nxt;
    logic [7:0]    rx_dat;
    logic          rx_vld, rx_ferr, rx_act;
    logic          is_wr, nak, collecting, abort, tx_last;
    logic [1:0]    idx;
    logic [31:0]   addr_sh, data_sh, rsp_buf;
    logic [TW-1:0] tmo_cnt;
    logic [9:0]    tx_shift;
    logic [CW-1:0] tx_baud;
    logic [3:0]    tx_bit;
    logic [2:0]    tx_left;
`ifdef UART_BRIDGE_CSUM_EN
    logic [7:0]    csum;
`endif

    uart_bridge_rx_byte #(.BAUDCNT(BAUDCNT)) u_rx (
        .clk_48m   (clk_48m),
        .rstn      (rstn),
        .rxd       (rxd),
        .byte_dat  (rx_dat),
        .byte_vld  (rx_vld),
        .byte_ferr (rx_ferr),
        .active    (rx_act)
    );

`ifdef UART_BRIDGE_CSUM_EN
    assign collecting = (state == S_ADDR) || (state == S_DATA) || (state == S_CSUM);
`else
    assign collecting = (state == S_ADDR) || (state == S_DATA);
`endif
    assign abort   = collecting && (rx_ferr || (tmo_cnt == TMO_M1));
    assign tx_last = (state == S_RESP) && (tx_baud == FULL_M1) && (tx_bit == 4'd9) && (tx_left == 3'd1);

    assign bus_req = (state == S_REQ) || (state == S_ACC);
    assign m_sel   = (state == S_ACC);
    assign m_rd    = (state == S_ACC) && !is_wr;
    assign m_wr    = (state == S_ACC) && is_wr;
    assign busy    = (state != S_IDLE);
    // Reset forces the line idle immediately rather than waiting for the edge.
    assign txd     = tx_shift[0] | ~rstn;

    always_ff @(posedge clk_48m) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        nak       = 1'b0;
        case (state)
            S_IDLE: if (rx_vld) begin
                if (rx_dat == CMD_WR || rx_dat == CMD_RD) begin
                    state_nxt = S_ADDR;
                end else begin
                    state_nxt = S_RESP;
                    nak       = 1'b1;
                end
            end
            S_ADDR: if (abort)                    state_nxt = S_IDLE;
                    else if (rx_vld && idx == 2'd3) state_nxt = is_wr ? S_DATA : AFTER_FIELDS;
            S_DATA: if (abort)                    state_nxt = S_IDLE;
                    else if (rx_vld && idx == 2'd3) state_nxt = AFTER_FIELDS;
`ifdef UART_BRIDGE_CSUM_EN
            S_CSUM: if (abort) begin
                state_nxt = S_IDLE;
            end else if (rx_vld) begin
                if (rx_dat == csum) begin
                    state_nxt = S_REQ;
                end else begin
                    state_nxt = S_RESP;
                    nak       = 1'b1;
                end
            end
`endif
            S_REQ:  if (bus_gnt) state_nxt = S_ACC;
            S_ACC:  state_nxt = S_RESP;
            S_RESP: if (tx_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_48m) begin
        if (!rstn) begin
            is_wr    <= 1'b0;
            idx      <= '0;
            addr_sh  <= '0;
            data_sh  <= '0;
            tmo_cnt  <= '0;
            m_addr   <= '0;
            m_data_o <= '0;
            rsp_buf  <= '0;
            tx_shift <= '1;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_left  <= '0;
`ifdef UART_BRIDGE_CSUM_EN
            csum     <= '0;
`endif
        end else begin
            if (state == S_IDLE) begin
                idx     <= '0;
                tmo_cnt <= '0;
                if (rx_vld) begin
                    is_wr <= (rx_dat == CMD_WR);
`ifdef UART_BRIDGE_CSUM_EN
                    csum  <= rx_dat;
`endif
                end
            end
            if (collecting) begin
                // Gap timer restarts whenever a byte is on the wire.
                tmo_cnt <= (rx_act || rx_vld) ? '0 : tmo_cnt + 1'b1;
                if (rx_vld) begin
                    idx <= idx + 1'b1;
`ifdef UART_BRIDGE_CSUM_EN
                    csum <= csum ^ rx_dat;
`endif
                    if (state == S_ADDR) addr_sh <= {rx_dat, addr_sh[31:8]};
                    if (state == S_DATA) data_sh <= {rx_dat, data_sh[31:8]};
                end
            end
            if (state == S_REQ && bus_gnt) begin
                m_addr <= addr_sh;
                if (is_wr) m_data_o <= data_sh;
            end
            if (state_nxt == S_RESP && state != S_RESP) begin
                tx_baud <= '0;
                tx_bit  <= '0;
                if (state == S_ACC && !is_wr) begin
                    rsp_buf  <= m_data_i;
                    tx_shift <= {1'b1, m_data_i[7:0], 1'b0};
                    tx_left  <= 3'd4;
                end else begin
                    tx_shift <= {1'b1, (nak ? RSP_NAK : RSP_ACK), 1'b0};
                    tx_left  <= 3'd1;
                end
            end else if (state == S_RESP) begin
                if (tx_baud == FULL_M1) begin
                    tx_baud <= '0;
                    if (tx_bit == 4'd9) begin
                        tx_bit  <= '0;
                        tx_left <= tx_left - 1'b1;
                        if (tx_left == 3'd1) begin
                            tx_shift <= '1;
                        end else begin
                            tx_shift <= {1'b1, rsp_buf[15:8], 1'b0};
                            rsp_buf  <= rsp_buf >> 8;
                        end
                    end else begin
                        tx_shift <= {1'b1, tx_shift[9:1]};
                        tx_bit   <= tx_bit + 1'b1;
                    end
                end else begin
                    tx_baud <= tx_baud + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Randomised self-checking bench for uart_bus_bridge against a frame-level reference model.
// Run with UART_BRIDGE_CSUM_EN defined to cover the checksum build.
module tb_uart_bus_bridge;
    import uart_bridge_pkg::*;

    localparam int BAUD = 8;
    localparam int TMO  = 400;

    logic        clk_48m = 1'b0;
    logic        rstn, rxd, txd, bus_req, bus_gnt, m_sel, m_rd, m_wr, busy;
    logic [31:0] m_addr, m_data_o, m_data_i;

    always #5 clk_48m = ~clk_48m;

    uart_bus_bridge #(.BAUDCNT(BAUD), .TMO_CYCLES(TMO)) dut (
        .clk_48m  (clk_48m),
        .rstn     (rstn),
        .rxd      (rxd),
        .txd      (txd),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .m_sel    (m_sel),
        .m_addr   (m_addr),
        .m_data_o (m_data_o),
        .m_data_i (m_data_i),
        .m_rd     (m_rd),
        .m_wr     (m_wr),
        .busy     (busy)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observation records, written only by the monitors below.
    logic [8:0]  rsp_q[$];
    logic        acc_wr_q[$];
    logic [31:0] acc_addr_q[$];
    logic [31:0] acc_data_q[$];
    int rd_cyc = 0, wr_cyc = 0, req_rise = 0, viol = 0;
    int mon_gen = 0;
    int gnt_dly = 0, gcnt = 0;
    logic req_prev = 1'b0;
    int   g;
    logic [8:0] sh;

    initial begin : tx_mon
        forever begin
            @(negedge clk_48m);
            if (rstn && txd == 1'b0) begin
                g = mon_gen;
                repeat (BAUD / 2) @(negedge clk_48m);
                for (int i = 0; i < 9; i++) begin
                    repeat (BAUD) @(negedge clk_48m);
                    sh = {txd, sh[8:1]};
                end
                if (g == mon_gen) rsp_q.push_back(sh);
            end
        end
    end

    initial begin : bus_mon
        forever begin
            @(negedge clk_48m);
            if (rstn) begin
                if (m_sel) begin
                    acc_wr_q.push_back(m_wr);
                    acc_addr_q.push_back(m_addr);
                    acc_data_q.push_back(m_data_o);
                end
                if (m_rd) rd_cyc++;
                if (m_wr) wr_cyc++;
                if (((m_rd || m_wr) != m_sel) || (m_rd && m_wr) || (m_sel && !bus_gnt)) viol++;
                if (bus_req && !req_prev) req_rise++;
            end
            req_prev = bus_req;
        end
    end

    initial begin : arbiter
        bus_gnt = 1'b0;
        forever begin
            @(negedge clk_48m);
            if (!bus_req) begin
                bus_gnt = 1'b0;
                gcnt    = 0;
            end else if (!bus_gnt) begin
                if (gcnt >= gnt_dly) bus_gnt = 1'b1;
                else gcnt++;
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog expired");
    end

    logic [7:0]  frm[$];
    logic [31:0] sdata;
    int b_rsp, b_acc, b_rd, b_wr, b_req, b_viol;

    task automatic snap();
        b_rsp  = rsp_q.size();
        b_acc  = acc_addr_q.size();
        b_rd   = rd_cyc;
        b_wr   = wr_cyc;
        b_req  = req_rise;
        b_viol = viol;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stp);
        logic [9:0] f;
        f = {stp, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (BAUD) @(negedge clk_48m);
        end
        rxd = 1'b1;
    endtask

    task automatic send_frame();
        foreach (frm[i]) send_byte(frm[i], 1'b1);
    endtask

    task automatic add_csum();
`ifdef UART_BRIDGE_CSUM_EN
        logic [7:0] x = 8'h00;
        foreach (frm[i]) x ^= frm[i];
        frm.push_back(x);
`endif
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 4000) begin
            @(negedge clk_48m);
            n++;
        end
        chk({tag, " idle"}, {31'd0, busy}, 32'd0);
        repeat (BAUD * 2) @(negedge clk_48m);
    endtask

    // Reference: what the host should see for the frame in frm.
    task automatic check_frame(input string tag);
        logic [7:0]  exp_q[$];
        logic [31:0] ea, ed;
        logic [7:0]  x;
        int kind, nb, ncs, na;
        logic [8:0]  got;
        kind = 0;
        ea   = '0;
        ed   = '0;
`ifdef UART_BRIDGE_CSUM_EN
        ncs = 1;
`else
        ncs = 0;
`endif
        nb = (frm[0] == 8'h57) ? 9 : (frm[0] == 8'h52) ? 5 : 1;
        if (nb == 1) begin
            exp_q.push_back(8'h15);
        end else if (frm.size() >= nb + ncs) begin
            x = 8'h00;
            for (int i = 0; i < nb; i++) x ^= frm[i];
            if (ncs == 1 && x != frm[nb]) begin
                exp_q.push_back(8'h15);
            end else begin
                ea = {frm[4], frm[3], frm[2], frm[1]};
                if (nb == 9) begin
                    kind = 1;
                    ed   = {frm[8], frm[7], frm[6], frm[5]};
                    exp_q.push_back(8'h06);
                end else begin
                    kind = 2;
                    for (int i = 0; i < 4; i++) exp_q.push_back(sdata[8*i +: 8]);
                end
            end
        end
        chk({tag, " rsp_cnt"}, 32'(rsp_q.size() - b_rsp), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (b_rsp + i < rsp_q.size()) ? rsp_q[b_rsp + i] : 9'h000;
            chk($sformatf("%s rsp[%0d]", tag, i), {23'd0, got}, {23'd0, 1'b1, exp_q[i]});
        end
        na = acc_addr_q.size() - b_acc;
        chk({tag, " acc_cnt"}, 32'(na), 32'(kind != 0));
        if (kind != 0 && na > 0) begin
            chk({tag, " acc_wr"}, {31'd0, acc_wr_q[b_acc]}, 32'(kind == 1));
            chk({tag, " acc_addr"}, acc_addr_q[b_acc], ea);
            if (kind == 1) chk({tag, " acc_wdata"}, acc_data_q[b_acc], ed);
        end
        chk({tag, " rd_cycles"}, 32'(rd_cyc - b_rd), 32'(kind == 2));
        chk({tag, " wr_cycles"}, 32'(wr_cyc - b_wr), 32'(kind == 1));
        chk({tag, " req_rise"}, 32'(req_rise - b_req), 32'(kind != 0));
        chk({tag, " protocol"}, 32'(viol - b_viol), 32'd0);
    endtask

    task automatic run(input string tag);
        snap();
        send_frame();
        wait_idle(tag);
        check_frame(tag);
    endtask

    initial begin : main
        logic [31:0] a, d;
        logic [7:0]  c;
        int k, n;
        rstn     = 1'b0;
        rxd      = 1'b1;
        m_data_i = '0;
        sdata    = '0;
        repeat (4) @(negedge clk_48m);
        rstn = 1'b1;
        @(negedge clk_48m);
        chk("rst txd",      {31'd0, txd},     32'd1);
        chk("rst bus_req",  {31'd0, bus_req}, 32'd0);
        chk("rst m_sel",    {31'd0, m_sel},   32'd0);
        chk("rst m_rd",     {31'd0, m_rd},    32'd0);
        chk("rst m_wr",     {31'd0, m_wr},    32'd0);
        chk("rst m_addr",   m_addr,           32'd0);
        chk("rst m_data_o", m_data_o,         32'd0);
        chk("rst busy",     {31'd0, busy},    32'd0);
        repeat (BAUD * 2) @(negedge clk_48m);

        // Write with delayed grant
        frm = '{8'h57, 8'h00, 8'h01, 8'h00, 8'h20, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        add_csum();
        gnt_dly = 5;
        snap();
        send_frame();
        chk("t1 busy", {31'd0, busy}, 32'd1);
        wait_idle("t1");
        check_frame("t1");
        chk("t1 m_addr hold",   m_addr,   32'h2000_0100);
        chk("t1 m_data_o hold", m_data_o, 32'hDEAD_BEEF);

        // Read
        gnt_dly  = 0;
        sdata    = 32'h0000_002A;
        m_data_i = sdata;
        frm = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h20};
        add_csum();
        run("t2");

        // Unknown command, then a normal read
        frm = '{8'h41};
        run("t3 nak");
        sdata    = 32'hC0FF_EE11;
        m_data_i = sdata;
        frm = '{8'h52, 8'h04, 8'h10, 8'h00, 8'h40};
        add_csum();
        run("t3 rd");

        // Stalled frame times out; following read must be served
        snap();
        frm = '{8'h57, 8'h00, 8'h01};
        send_frame();
        repeat (TMO + 100) @(negedge clk_48m);
        chk("t4 abort busy", {31'd0, busy}, 32'd0);
        sdata    = 32'h1234_5678;
        m_data_i = sdata;
        frm = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h20};
        add_csum();
        send_frame();
        wait_idle("t4");
        check_frame("t4");

        // Framing error on third byte aborts silently
        frm = '{8'h52, 8'h08, 8'h00};
        snap();
        send_byte(frm[0], 1'b1);
        send_byte(frm[1], 1'b1);
        send_byte(frm[2], 1'b0);
        repeat (200) @(negedge clk_48m);
        chk("t5 ferr busy", {31'd0, busy}, 32'd0);
        check_frame("t5 ferr");

        // Reset in the middle of a reply
        sdata    = 32'hA5A5_0F0F;
        m_data_i = sdata;
        frm = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h20};
        add_csum();
        send_frame();
        n = 0;
        while (txd && n < 2000) begin
            @(negedge clk_48m);
            n++;
        end
        chk("t5 reply start", {31'd0, txd}, 32'd0);
        repeat (20) @(negedge clk_48m);
        rstn = 1'b0;
        mon_gen++;
        #1;
        chk("t5 txd at once", {31'd0, txd}, 32'd1);
        @(negedge clk_48m);
        chk("t5 rst txd",     {31'd0, txd},     32'd1);
        chk("t5 rst busy",    {31'd0, busy},    32'd0);
        chk("t5 rst bus_req", {31'd0, bus_req}, 32'd0);
        chk("t5 rst m_addr",  m_addr,           32'd0);
        rstn = 1'b1;
        repeat (BAUD * 12) @(negedge clk_48m);

`ifdef UART_BRIDGE_CSUM_EN
        sdata    = 32'h0BAD_F00D;
        m_data_i = sdata;
        frm = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h20, 8'h7A};
        run("t6 good");
        frm = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h20, 8'h7B};
        run("t6 bad");
`endif

        for (int it = 0; it < 14; it++) begin
            k = $urandom_range(0, 9);
            frm.delete();
            if (k < 2) begin
                do c = 8'($urandom); while (c == CMD_WR || c == CMD_RD);
                frm.push_back(c);
            end else begin
                a = $urandom;
                d = $urandom;
                frm.push_back(k < 6 ? CMD_WR : CMD_RD);
                for (int i = 0; i < 4; i++) frm.push_back(a[8*i +: 8]);
                if (k < 6) for (int i = 0; i < 4; i++) frm.push_back(d[8*i +: 8]);
                add_csum();
`ifdef UART_BRIDGE_CSUM_EN
                if ($urandom_range(0, 3) == 0) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
`endif
            end
            gnt_dly  = $urandom_range(0, 12);
            sdata    = $urandom;
            m_data_i = sdata;
            run($sformatf("rnd%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
